// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage (ALU ops, forwarding selects,
// multiplier FSM states, EX/MEM control bundle).
package ex_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MUL_CYCLES = DATA_WIDTH;
    localparam int SHAMT_W    = $clog2(DATA_WIDTH);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULH  = 4'd11,
        ALU_MULHU = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_WB     = 2'b01,
        FWD_MEM    = 2'b10,
        FWD_RF_ALT = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } ex_state_e;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memread;
        logic memwrite;
    } ctrl_t;

    localparam ctrl_t ALU_BUBBLE = '0;

    function automatic logic is_mul_op(input alu_op_e op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
    endfunction

endpackage

// File: rtl/ex_if.sv
// ID/EX inputs, forwarding/hazard signals and EX/MEM outputs of the execute stage.
// slave = the execute stage, master = its surroundings.
interface ex_if;
    import ex_pkg::*;

    logic                  HDU__EX_flush;
    logic                  stage_ID_EX__EX_regwrite;
    logic                  stage_ID_EX__EX_memtoreg;
    logic                  stage_ID_EX__EX_memread;
    logic                  stage_ID_EX__EX_memwrite;
    alu_op_e               stage_ID_EX__EX_alu_op;
    logic                  stage_ID_EX__EX_alusrc;
    logic [DATA_WIDTH-1:0] stage_ID_EX__EX_rs1_data;
    logic [DATA_WIDTH-1:0] stage_ID_EX__EX_rs2_data;
    logic [DATA_WIDTH-1:0] stage_ID_EX__EX_imm;
    logic [REG_ADDR_W-1:0] stage_ID_EX__EX_rd_id;
    fwd_sel_e              FU__EX_fwd_a;
    fwd_sel_e              FU__EX_fwd_b;
    logic [DATA_WIDTH-1:0] MEM__EX_for_help;
    logic [DATA_WIDTH-1:0] WB__EX_wbdata;

    logic                  EX__HDU_busy;
    logic                  stage_EX_MEM__MEM_regwrite;
    logic                  stage_EX_MEM__MEM_memtoreg;
    logic                  stage_EX_MEM__MEM_memread;
    logic                  stage_EX_MEM__MEM_memwrite;
    logic [DATA_WIDTH-1:0] stage_EX_MEM__MEM_alures;
    logic [DATA_WIDTH-1:0] stage_EX_MEM__MEM_store_data;
    logic [REG_ADDR_W-1:0] stage_EX_MEM__MEM_rd_id;

    modport master (
        output HDU__EX_flush,
        output stage_ID_EX__EX_regwrite, stage_ID_EX__EX_memtoreg,
        output stage_ID_EX__EX_memread, stage_ID_EX__EX_memwrite,
        output stage_ID_EX__EX_alu_op, stage_ID_EX__EX_alusrc,
        output stage_ID_EX__EX_rs1_data, stage_ID_EX__EX_rs2_data,
        output stage_ID_EX__EX_imm, stage_ID_EX__EX_rd_id,
        output FU__EX_fwd_a, FU__EX_fwd_b, MEM__EX_for_help, WB__EX_wbdata,
        input  EX__HDU_busy,
        input  stage_EX_MEM__MEM_regwrite, stage_EX_MEM__MEM_memtoreg,
        input  stage_EX_MEM__MEM_memread, stage_EX_MEM__MEM_memwrite,
        input  stage_EX_MEM__MEM_alures, stage_EX_MEM__MEM_store_data,
        input  stage_EX_MEM__MEM_rd_id
    );

    modport slave (
        input  HDU__EX_flush,
        input  stage_ID_EX__EX_regwrite, stage_ID_EX__EX_memtoreg,
        input  stage_ID_EX__EX_memread, stage_ID_EX__EX_memwrite,
        input  stage_ID_EX__EX_alu_op, stage_ID_EX__EX_alusrc,
        input  stage_ID_EX__EX_rs1_data, stage_ID_EX__EX_rs2_data,
        input  stage_ID_EX__EX_imm, stage_ID_EX__EX_rd_id,
        input  FU__EX_fwd_a, FU__EX_fwd_b, MEM__EX_for_help, WB__EX_wbdata,
        output EX__HDU_busy,
        output stage_EX_MEM__MEM_regwrite, stage_EX_MEM__MEM_memtoreg,
        output stage_EX_MEM__MEM_memread, stage_EX_MEM__MEM_memwrite,
        output stage_EX_MEM__MEM_alures, stage_EX_MEM__MEM_store_data,
        output stage_EX_MEM__MEM_rd_id
    );

endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: IDLE/BUSY/DONE FSM, iteration counter, accumulator.
// EX_MULH_EN widens the accumulator to 2*W and enables MULH/MULHU high-half results.
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int W      = DATA_WIDTH,
    parameter int CYCLES = MUL_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         flush,
    input  logic         start,
    input  alu_op_e      op,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

`ifdef EX_MULH_EN
    localparam int ACC_W = 2 * W;
`else
    localparam int ACC_W = W;
`endif
    localparam int              CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    ex_state_e        state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc, mcand;
    logic [W-1:0]     mplier;
    logic [W-1:0]     mag_a, mag_b;
    logic             launch, step;

    assign launch = (state == S_IDLE) && start && en && !flush;
    assign step   = (state == S_BUSY) && en && !flush;
    // Kept independent of flush so the hazard unit sees no combinational loop.
    assign busy   = (state == S_BUSY) || ((state == S_IDLE) && start && en);
    assign done   = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            state <= S_IDLE;
        else if (en || flush)  state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_BUSY;
            S_BUSY:  if (cnt == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (launch) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= ACC_W'(mag_a);
            mplier <= mag_b;
        end else if (step) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

`ifdef EX_MULH_EN
    logic             neg, hi_sel, neg_d;
    logic [ACC_W-1:0] sacc;

    // MULH multiplies magnitudes and fixes the sign at the end.
    always_comb begin
        mag_a = op_a;
        mag_b = op_b;
        neg_d = 1'b0;
        if (op == ALU_MULH) begin
            mag_a = op_a[W-1] ? -op_a : op_a;
            mag_b = op_b[W-1] ? -op_b : op_b;
            neg_d = op_a[W-1] ^ op_b[W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg    <= 1'b0;
            hi_sel <= 1'b0;
        end else if (launch) begin
            neg    <= neg_d;
            hi_sel <= (op != ALU_MUL);
        end
    end

    assign sacc    = neg ? -acc : acc;
    assign product = hi_sel ? sacc[ACC_W-1:W] : sacc[W-1:0];
`else
    logic unused_op;
    assign unused_op = ^op;
    assign mag_a     = op_a;
    assign mag_b     = op_b;
    assign product   = acc;
`endif

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative multiplier and the
// EX/MEM pipeline register. EX_MULH_EN enables high-half MULH/MULHU results.
module ex_stage
    import ex_pkg::*;
(
    input logic clk,
    input logic rst_n,
    input logic en,
    ex_if.slave bus
);

    logic [DATA_WIDTH-1:0] op_a, op_b_fwd, op_b, alu_res, mul_product;
    logic [SHAMT_W-1:0]    shamt;
    logic                  is_mul, mul_busy, mul_done;
    ctrl_t                 id_ctrl, mem_ctrl;
    logic [DATA_WIDTH-1:0] mem_alures, mem_store;
    logic [REG_ADDR_W-1:0] mem_rd;

    always_comb begin
        case (bus.FU__EX_fwd_a)
            FWD_WB:  op_a = bus.WB__EX_wbdata;
            FWD_MEM: op_a = bus.MEM__EX_for_help;
            default: op_a = bus.stage_ID_EX__EX_rs1_data;
        endcase
        case (bus.FU__EX_fwd_b)
            FWD_WB:  op_b_fwd = bus.WB__EX_wbdata;
            FWD_MEM: op_b_fwd = bus.MEM__EX_for_help;
            default: op_b_fwd = bus.stage_ID_EX__EX_rs2_data;
        endcase
    end

    // Store data is the forwarded rs2, never the immediate.
    assign op_b  = bus.stage_ID_EX__EX_alusrc ? bus.stage_ID_EX__EX_imm : op_b_fwd;
    assign shamt = op_b[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (bus.stage_ID_EX__EX_alu_op)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLT:  alu_res = DATA_WIDTH'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res = DATA_WIDTH'(op_a < op_b);
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
            default:  alu_res = '0;
        endcase
    end

    assign is_mul  = is_mul_op(bus.stage_ID_EX__EX_alu_op);
    assign id_ctrl = '{bus.stage_ID_EX__EX_regwrite, bus.stage_ID_EX__EX_memtoreg,
                       bus.stage_ID_EX__EX_memread, bus.stage_ID_EX__EX_memwrite};

    ex_mul_iter #(.W(DATA_WIDTH), .CYCLES(MUL_CYCLES)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .flush   (bus.HDU__EX_flush),
        .start   (is_mul),
        .op      (bus.stage_ID_EX__EX_alu_op),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ctrl   <= ALU_BUBBLE;
            mem_alures <= '0;
            mem_store  <= '0;
            mem_rd     <= '0;
        end else if (bus.HDU__EX_flush) begin
            mem_ctrl   <= ALU_BUBBLE;
            mem_alures <= '0;
            mem_store  <= '0;
            mem_rd     <= '0;
        end else if (en) begin
            if (mul_done) begin
                mem_ctrl   <= id_ctrl;
                mem_alures <= mul_product;
                mem_store  <= op_b_fwd;
                mem_rd     <= bus.stage_ID_EX__EX_rd_id;
            end else if (is_mul || mul_busy) begin
                mem_ctrl   <= ALU_BUBBLE;
                mem_alures <= '0;
                mem_store  <= '0;
                mem_rd     <= '0;
            end else begin
                mem_ctrl   <= id_ctrl;
                mem_alures <= alu_res;
                mem_store  <= op_b_fwd;
                mem_rd     <= bus.stage_ID_EX__EX_rd_id;
            end
        end
    end

    assign bus.EX__HDU_busy                 = mul_busy;
    assign bus.stage_EX_MEM__MEM_regwrite   = mem_ctrl.regwrite;
    assign bus.stage_EX_MEM__MEM_memtoreg   = mem_ctrl.memtoreg;
    assign bus.stage_EX_MEM__MEM_memread    = mem_ctrl.memread;
    assign bus.stage_EX_MEM__MEM_memwrite   = mem_ctrl.memwrite;
    assign bus.stage_EX_MEM__MEM_alures     = mem_alures;
    assign bus.stage_EX_MEM__MEM_store_data = mem_store;
    assign bus.stage_EX_MEM__MEM_rd_id      = mem_rd;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, ALU ops, forwarding, multiplier latency/stall,
// flush and reset mid-multiply. Expected MULH/MULHU values follow EX_MULH_EN.
module tb_ex_stage;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst_n, en;
    int   checks = 0;
    int   failures = 0;

    ex_if bus();

    ex_stage dut (.clk(clk), .rst_n(rst_n), .en(en), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input alu_op_e op, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic alusrc, input logic [4:0] rd,
                          input logic [3:0] ctl);
        bus.stage_ID_EX__EX_alu_op   = op;
        bus.stage_ID_EX__EX_rs1_data = rs1;
        bus.stage_ID_EX__EX_rs2_data = rs2;
        bus.stage_ID_EX__EX_imm      = imm;
        bus.stage_ID_EX__EX_alusrc   = alusrc;
        bus.stage_ID_EX__EX_rd_id    = rd;
        {bus.stage_ID_EX__EX_regwrite, bus.stage_ID_EX__EX_memtoreg,
         bus.stage_ID_EX__EX_memread, bus.stage_ID_EX__EX_memwrite} = ctl;
    endtask

    function automatic logic [31:0] ctl_out();
        return {28'd0, bus.stage_EX_MEM__MEM_regwrite, bus.stage_EX_MEM__MEM_memtoreg,
                bus.stage_EX_MEM__MEM_memread, bus.stage_EX_MEM__MEM_memwrite};
    endfunction

    // Presents a multiply at cycle 0 and follows it until the result lands in EX/MEM.
    // The ID/EX slot is cleared once busy drops, as the front end would do.
    task automatic run_mul(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input int stall_at, input int stall_len,
                           output int busy_cyc, output int res_cyc,
                           output logic bub_ok, output logic [31:0] res);
        logic sw;
        busy_cyc = 0; res_cyc = -1; bub_ok = 1'b1; res = '0; sw = 1'b0;
        set_id(op, a, b, 32'd0, 1'b0, 5'd9, 4'b1000);
        for (int c = 0; c < 60 && res_cyc < 0; c++) begin
            en = !(c >= stall_at && c < stall_at + stall_len);
            #1;
            if (c > 0 && bus.stage_EX_MEM__MEM_regwrite === 1'b1) begin
                res_cyc = c;
                res     = bus.stage_EX_MEM__MEM_alures;
            end else if (c > 0 && (bus.stage_EX_MEM__MEM_alures !== 32'd0 ||
                                   bus.stage_EX_MEM__MEM_rd_id !== 5'd0)) begin
                bub_ok = 1'b0;
            end
            if (bus.EX__HDU_busy === 1'b1) busy_cyc++;
            else if (c > 0) sw = 1'b1;
            @(posedge clk);
            #1;
            if (sw) set_id(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000);
        end
        en = 1'b1;
    endtask

    initial begin
        int          bc, rc;
        logic        bo;
        logic [31:0] r;

        rst_n = 1'b0;
        en    = 1'b1;
        bus.HDU__EX_flush    = 1'b0;
        bus.FU__EX_fwd_a     = FWD_RF;
        bus.FU__EX_fwd_b     = FWD_RF;
        bus.MEM__EX_for_help = 32'd0;
        bus.WB__EX_wbdata    = 32'd0;
        set_id(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000);
        repeat (20) tick();
        chk("rst_alures", bus.stage_EX_MEM__MEM_alures, 32'd0);
        chk("rst_store",  bus.stage_EX_MEM__MEM_store_data, 32'd0);
        chk("rst_rd",     32'(bus.stage_EX_MEM__MEM_rd_id), 32'd0);
        chk("rst_ctl",    ctl_out(), 32'd0);
        chk("rst_busy",   32'(bus.EX__HDU_busy), 32'd0);
        rst_n = 1'b1;

        set_id(ALU_ADD, 32'd5, 32'd0, 32'd7, 1'b1, 5'd3, 4'b1000);
        tick();
        chk("add_res", bus.stage_EX_MEM__MEM_alures, 32'd12);
        chk("add_rd",  32'(bus.stage_EX_MEM__MEM_rd_id), 32'd3);
        chk("add_ctl", ctl_out(), 32'h8);

        bus.FU__EX_fwd_a     = FWD_MEM;
        bus.MEM__EX_for_help = 32'd100;
        set_id(ALU_SUB, 32'd0, 32'd1, 32'd0, 1'b0, 5'd4, 4'b1000);
        tick();
        chk("fwd_a_sub", bus.stage_EX_MEM__MEM_alures, 32'd99);

        bus.FU__EX_fwd_a  = FWD_RF;
        bus.FU__EX_fwd_b  = FWD_WB;
        bus.WB__EX_wbdata = 32'h55;
        set_id(ALU_ADD, 32'd0, 32'd1, 32'd0, 1'b0, 5'd0, 4'b0001);
        tick();
        chk("fwd_b_store", bus.stage_EX_MEM__MEM_store_data, 32'h55);
        chk("fwd_b_ctl",   ctl_out(), 32'h1);
        chk("fwd_b_res",   bus.stage_EX_MEM__MEM_alures, 32'h55);
        bus.FU__EX_fwd_b = FWD_RF;

        set_id(ALU_SRA, 32'hFFFF_FFF8, 32'd1, 32'd0, 1'b0, 5'd5, 4'b1000);
        tick();
        chk("sra", bus.stage_EX_MEM__MEM_alures, 32'hFFFF_FFFC);
        set_id(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd5, 4'b1000);
        tick();
        chk("sltu", bus.stage_EX_MEM__MEM_alures, 32'd1);
        set_id(ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd5, 4'b1000);
        tick();
        chk("slt", bus.stage_EX_MEM__MEM_alures, 32'd0);
        set_id(ALU_SLL, 32'h0000_0003, 32'd0, 32'd4, 1'b1, 5'd6, 4'b1000);
        tick();
        chk("sll_imm", bus.stage_EX_MEM__MEM_alures, 32'h30);
        set_id(alu_op_e'(4'd15), 32'd5, 32'd5, 32'd0, 1'b0, 5'd7, 4'b1010);
        tick();
        chk("unused_res", bus.stage_EX_MEM__MEM_alures, 32'd0);
        chk("unused_ctl", ctl_out(), 32'hA);

        run_mul(ALU_MUL, 32'd6, 32'd7, -1, 0, bc, rc, bo, r);
        chk("mul_busy_cycles", 32'(bc), 32'd33);
        chk("mul_res_cycle",   32'(rc), 32'd34);
        chk("mul_res",         r, 32'd42);
        chk("mul_bubbles",     32'(bo), 32'd1);

        run_mul(ALU_MUL, 32'd6, 32'd7, 10, 5, bc, rc, bo, r);
        chk("mul_stall_busy",  32'(bc), 32'd38);
        chk("mul_stall_cycle", 32'(rc), 32'd39);
        chk("mul_stall_res",   r, 32'd42);

        run_mul(ALU_MULHU, 32'hFFFF_FFFF, 32'd2, -1, 0, bc, rc, bo, r);
        chk("mulhu_cycle", 32'(rc), 32'd34);
`ifdef EX_MULH_EN
        chk("mulhu_res", r, 32'd1);
`else
        chk("mulhu_res", r, 32'hFFFF_FFFE);
`endif
        run_mul(ALU_MULH, 32'hFFFF_FFFD, 32'd5, -1, 0, bc, rc, bo, r);
`ifdef EX_MULH_EN
        chk("mulh_res", r, 32'hFFFF_FFFF);
`else
        chk("mulh_res", r, 32'hFFFF_FFF1);
`endif

        // Flush with the multiplier at counter 5 (cycle 6).
        set_id(ALU_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 5'd9, 4'b1000);
        repeat (6) tick();
        bus.HDU__EX_flush = 1'b1;
        #1;
        chk("flush_busy_before", 32'(bus.EX__HDU_busy), 32'd1);
        tick();
        bus.HDU__EX_flush = 1'b0;
        set_id(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000);
        #1;
        chk("flush_busy_after", 32'(bus.EX__HDU_busy), 32'd0);
        chk("flush_ctl",        ctl_out(), 32'd0);
        set_id(ALU_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 5'd1, 4'b1000);
        tick();
        chk("flush_then_add", bus.stage_EX_MEM__MEM_alures, 32'd5);

        // Reset with the multiplier at counter 10 (cycle 11).
        set_id(ALU_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 5'd9, 4'b1000);
        repeat (11) tick();
        #1;
        chk("midrst_busy_before", 32'(bus.EX__HDU_busy), 32'd1);
        rst_n = 1'b0;
        set_id(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000);
        #1;
        chk("midrst_busy",   32'(bus.EX__HDU_busy), 32'd0);
        chk("midrst_alures", bus.stage_EX_MEM__MEM_alures, 32'd0);
        chk("midrst_ctl",    ctl_out(), 32'd0);
        tick();
        rst_n = 1'b1;
        set_id(ALU_ADD, 32'd4, 32'd4, 32'd0, 1'b0, 5'd2, 4'b1000);
        tick();
        chk("midrst_add", bus.stage_EX_MEM__MEM_alures, 32'd8);
        run_mul(ALU_MUL, 32'd3, 32'd5, -1, 0, bc, rc, bo, r);
        chk("midrst_mul_cycle", 32'(rc), 32'd34);
        chk("midrst_mul_res",   r, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
